// File: rtl/fwd_hazard_unit_pkg.sv
// Shared processor constants: forwarding-select encodings used by the hazard unit and the ALU stage.
package fwd_hazard_unit_pkg;

   localparam int unsigned FWD_SEL_W    = 2;
   localparam int unsigned REGW_DEFAULT = 5;

   typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

   // 2'd3 is reserved; consumers treat it as FWD_NONE.
   localparam fwd_sel_t FWD_NONE        = 2'd0;
   localparam fwd_sel_t FWD_FROM_EX_MEM = 2'd1;
   localparam fwd_sel_t FWD_FROM_MEM_WB = 2'd2;

   // EX/MEM holds the younger result, so it wins when both stages match.
   function automatic fwd_sel_t fwdSelect(input logic hitExMem, input logic hitMemWb);
      fwd_sel_t sel;
      sel = FWD_NONE;
      if (hitExMem) begin
         sel = FWD_FROM_EX_MEM;
      end else if (hitMemWb) begin
         sel = FWD_FROM_MEM_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-to-hazard-unit bundle: decode tags and flush in, stall and forwarding selects out.
interface fwd_hazard_unit_if #(
   parameter int unsigned REGW = 5
);
   import fwd_hazard_unit_pkg::*;

   logic            id_valid;
   logic [REGW-1:0] id_rs1;
   logic [REGW-1:0] id_rs2;
   logic            id_rs1_used;
   logic            id_rs2_used;
   logic [REGW-1:0] id_rd;
   logic            id_reg_write;
   logic            id_mem_read;
   logic            flush;
   logic            stall;
   fwd_sel_t        busA_sel;
   fwd_sel_t        busB_sel;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_reg_write, id_mem_read, flush,
      input  stall, busA_sel, busB_sel
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_reg_write, id_mem_read, flush,
      output stall, busA_sel, busB_sel
   );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Tag comparator: a live, GPR-writing stage whose non-zero rd equals a source that is actually read.
module fwd_match #(
   parameter int unsigned REGW = 5
) (
   input  logic            valid,
   input  logic            regWrite,
   input  logic [REGW-1:0] rd,
   input  logic [REGW-1:0] rs,
   input  logic            used,
   output logic            hit
);

   assign hit = valid & regWrite & used & (rd != '0) & (rd == rs);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Load-use stall detection and EX operand forwarding selects over a three-stage tag pipeline.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned REGW = REGW_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fwd_hazard_unit_if.slave      hz
);

   logic            idexValid;
   logic [REGW-1:0] idexRd;
   logic            idexRegWrite;
   logic            idexMemRead;
   logic [REGW-1:0] idexRs1;
   logic [REGW-1:0] idexRs2;
   logic            idexRs1Used;
   logic            idexRs2Used;

   logic            exmemValid;
   logic [REGW-1:0] exmemRd;
   logic            exmemRegWrite;
   logic            exmemMemRead;

   logic            memwbValid;
   logic [REGW-1:0] memwbRd;
   logic            memwbRegWrite;
   logic            memwbMemRead;

   logic            stallC;
   logic            rs1MatchC;
   logic            rs2MatchC;
   logic            useA;
   logic            useB;
   logic            hitAExMem;
   logic            hitAMemWb;
   logic            hitBExMem;
   logic            hitBMemWb;
   fwd_sel_t        selA;
   fwd_sel_t        selB;

   // Load in ID/EX whose destination is read by the instruction in decode.
   always_comb begin
      rs1MatchC = hz.id_rs1_used & (hz.id_rs1 == idexRd);
      rs2MatchC = hz.id_rs2_used & (hz.id_rs2 == idexRd);
      stallC    = hz.id_valid & idexValid & idexMemRead & (idexRd != '0)
                & (rs1MatchC | rs2MatchC);
   end

   // Tag pipeline; a stalled or flushed slot enters ID/EX as an all-zero bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idexValid     <= 1'b0;
         idexRd        <= '0;
         idexRegWrite  <= 1'b0;
         idexMemRead   <= 1'b0;
         idexRs1       <= '0;
         idexRs2       <= '0;
         idexRs1Used   <= 1'b0;
         idexRs2Used   <= 1'b0;
         exmemValid    <= 1'b0;
         exmemRd       <= '0;
         exmemRegWrite <= 1'b0;
         exmemMemRead  <= 1'b0;
         memwbValid    <= 1'b0;
         memwbRd       <= '0;
         memwbRegWrite <= 1'b0;
         memwbMemRead  <= 1'b0;
      end else begin
         memwbValid    <= exmemValid;
         memwbRd       <= exmemRd;
         memwbRegWrite <= exmemRegWrite;
         memwbMemRead  <= exmemMemRead;
         exmemValid    <= idexValid;
         exmemRd       <= idexRd;
         exmemRegWrite <= idexRegWrite;
         exmemMemRead  <= idexMemRead;
         if (hz.flush || stallC) begin
            idexValid    <= 1'b0;
            idexRd       <= '0;
            idexRegWrite <= 1'b0;
            idexMemRead  <= 1'b0;
            idexRs1      <= '0;
            idexRs2      <= '0;
            idexRs1Used  <= 1'b0;
            idexRs2Used  <= 1'b0;
         end else begin
            idexValid    <= hz.id_valid;
            idexRd       <= hz.id_rd;
            idexRegWrite <= hz.id_reg_write;
            idexMemRead  <= hz.id_mem_read;
            idexRs1      <= hz.id_rs1;
            idexRs2      <= hz.id_rs2;
            idexRs1Used  <= hz.id_rs1_used;
            idexRs2Used  <= hz.id_rs2_used;
         end
      end
   end

   assign useA = idexValid & idexRs1Used;
   assign useB = idexValid & idexRs2Used;

   fwd_match #(.REGW(REGW)) uMatchAExMem (
      .valid(exmemValid), .regWrite(exmemRegWrite), .rd(exmemRd),
      .rs(idexRs1), .used(useA), .hit(hitAExMem)
   );

   fwd_match #(.REGW(REGW)) uMatchAMemWb (
      .valid(memwbValid), .regWrite(memwbRegWrite), .rd(memwbRd),
      .rs(idexRs1), .used(useA), .hit(hitAMemWb)
   );

   fwd_match #(.REGW(REGW)) uMatchBExMem (
      .valid(exmemValid), .regWrite(exmemRegWrite), .rd(exmemRd),
      .rs(idexRs2), .used(useB), .hit(hitBExMem)
   );

   fwd_match #(.REGW(REGW)) uMatchBMemWb (
      .valid(memwbValid), .regWrite(memwbRegWrite), .rd(memwbRd),
      .rs(idexRs2), .used(useB), .hit(hitBMemWb)
   );

   assign selA = fwdSelect(hitAExMem, hitAMemWb);
   assign selB = fwdSelect(hitBExMem, hitBMemWb);

   assign hz.stall    = stallC;
   assign hz.busA_sel = selA;
   assign hz.busB_sel = selB;

   // The one-cycle load-use stall means a load never forwards out of EX/MEM.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(exmemMemRead && (hitAExMem || hitBExMem)));
         assert (!memwbMemRead || (memwbValid && memwbRegWrite));
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: hand-computed stall and forwarding selects per pipeline step.
module tb_fwd_hazard_unit;
   import fwd_hazard_unit_pkg::*;

   localparam int unsigned REGW = 5;

   logic clk;
   logic rst_n;
   int   nAsserts;
   int   nFails;

   fwd_hazard_unit_if #(.REGW(REGW)) hzIf ();

   fwd_hazard_unit #(.REGW(REGW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hzIf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setId(input logic v, input int rs1, input logic u1, input int rs2,
                        input logic u2, input int rd, input logic rw, input logic mr);
      hzIf.id_valid     = v;
      hzIf.id_rs1       = REGW'(rs1);
      hzIf.id_rs1_used  = u1;
      hzIf.id_rs2       = REGW'(rs2);
      hzIf.id_rs2_used  = u2;
      hzIf.id_rd        = REGW'(rd);
      hzIf.id_reg_write = rw;
      hzIf.id_mem_read  = mr;
   endtask

   task automatic nop();
      setId(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      hzIf.flush = 1'b0;
      nop();
      repeat (3) tick();
   endtask

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOut(input string tag, input logic expStall,
                           input fwd_sel_t expA, input fwd_sel_t expB);
      check({tag, ".stall"}, {1'b0, hzIf.stall}, {1'b0, expStall});
      check({tag, ".busA"}, hzIf.busA_sel, expA);
      check({tag, ".busB"}, hzIf.busB_sel, expB);
   endtask

   initial begin
      clk        = 1'b0;
      nAsserts   = 0;
      nFails     = 0;
      rst_n      = 1'b0;
      hzIf.flush = 1'b0;
      nop();

      tick();
      checkOut("rst_during", 1'b0, FWD_NONE, FWD_NONE);
      rst_n = 1'b1;
      tick();
      checkOut("rst_after", 1'b0, FWD_NONE, FWD_NONE);

      // add r3,r1,r2 ; sub r4,r3,r5
      setId(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      #1 check("add_nostall", {1'b0, hzIf.stall}, 2'd0);
      tick();
      setId(1'b1, 3, 1'b1, 5, 1'b1, 4, 1'b1, 1'b0);
      tick();
      checkOut("raw_exmem", 1'b0, FWD_FROM_EX_MEM, FWD_NONE);
      drain();

      // add r3 ; nop ; or r6,r7,r3
      setId(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      tick();
      nop();
      tick();
      setId(1'b1, 7, 1'b1, 3, 1'b1, 6, 1'b1, 1'b0);
      tick();
      checkOut("raw_memwb", 1'b0, FWD_NONE, FWD_FROM_MEM_WB);
      drain();

      // lw r8 ; add r9,r8,r1
      setId(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1);
      tick();
      setId(1'b1, 8, 1'b1, 1, 1'b1, 9, 1'b1, 1'b0);
      #1 checkOut("loaduse_stall", 1'b1, FWD_NONE, FWD_NONE);
      tick();
      checkOut("loaduse_bubble", 1'b0, FWD_NONE, FWD_NONE);
      tick();
      checkOut("loaduse_fwd", 1'b0, FWD_FROM_MEM_WB, FWD_NONE);
      drain();

      // add r3 ; add r3 ; and r10,r3,r3
      setId(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      tick();
      setId(1'b1, 4, 1'b1, 5, 1'b1, 3, 1'b1, 1'b0);
      tick();
      setId(1'b1, 3, 1'b1, 3, 1'b1, 10, 1'b1, 1'b0);
      tick();
      checkOut("youngest_wins", 1'b0, FWD_FROM_EX_MEM, FWD_FROM_EX_MEM);
      drain();

      // add r0,r1,r2 ; sub r4,r0,r0
      setId(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0);
      tick();
      setId(1'b1, 0, 1'b1, 0, 1'b1, 4, 1'b1, 1'b0);
      tick();
      checkOut("r0_nofwd", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      // lw r0 ; add r5,r0,r1
      setId(1'b1, 1, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1);
      tick();
      setId(1'b1, 0, 1'b1, 1, 1'b1, 5, 1'b1, 1'b0);
      #1 check("r0_nostall", {1'b0, hzIf.stall}, 2'd0);
      tick();
      checkOut("r0_load_nofwd", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      // add r3 ; addi r11,r3 (rs2 field aliases r3 but is unused)
      setId(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      tick();
      setId(1'b1, 3, 1'b1, 3, 1'b0, 11, 1'b1, 1'b0);
      tick();
      checkOut("imm_rs2_unused", 1'b0, FWD_FROM_EX_MEM, FWD_NONE);
      drain();

      // non-writing instruction with rd field r3 ; add r12,r3,r3
      setId(1'b1, 1, 1'b1, 3, 1'b1, 3, 1'b0, 1'b0);
      tick();
      setId(1'b1, 3, 1'b1, 3, 1'b1, 12, 1'b1, 1'b0);
      tick();
      checkOut("no_regwrite", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      // flushed add r3 ; sub r4,r3,r5
      setId(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
      hzIf.flush = 1'b1;
      tick();
      hzIf.flush = 1'b0;
      setId(1'b1, 3, 1'b1, 5, 1'b1, 4, 1'b1, 1'b0);
      tick();
      checkOut("flush_kill", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      // lw r8 ; add r9,r8,r1 with flush during the stall, then a reset cycle
      setId(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1);
      tick();
      setId(1'b1, 8, 1'b1, 1, 1'b1, 9, 1'b1, 1'b0);
      hzIf.flush = 1'b1;
      #1 check("flush_stall", {1'b0, hzIf.stall}, 2'd1);
      tick();
      hzIf.flush = 1'b0;
      rst_n = 1'b0;
      tick();
      checkOut("rst_mid", 1'b0, FWD_NONE, FWD_NONE);
      rst_n = 1'b1;
      tick();
      checkOut("rst_drop_lw", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      // reset in the middle of a plain load-use stall
      setId(1'b1, 2, 1'b1, 0, 1'b0, 8, 1'b1, 1'b1);
      tick();
      setId(1'b1, 8, 1'b1, 1, 1'b1, 9, 1'b1, 1'b0);
      #1 check("stall_pre_rst", {1'b0, hzIf.stall}, 2'd1);
      rst_n = 1'b0;
      tick();
      checkOut("rst_stall_clear", 1'b0, FWD_NONE, FWD_NONE);
      rst_n = 1'b1;
      tick();
      checkOut("rst_stall_after", 1'b0, FWD_NONE, FWD_NONE);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
